// File: rtl/key_event_decoder.sv
// Classifies debounced key activity on four keys into SHORT/LONG/DOUBLE/REPEAT events
// and serialises them through a single valid/ready command port, lowest key index first.
module key_event_decoder #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned LONG_CYCLES   = 100,
  parameter int unsigned REPEAT_CYCLES = 20,
  parameter int unsigned DBL_CYCLES    = 40
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_flag,
  input  logic [3:0] key_value,
  output logic       cmd_valid,
  output logic [1:0] cmd_key,
  output logic [1:0] cmd_type,
  input  logic       cmd_ready,
  output logic       evt_overflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRESS  = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_WAIT2  = 3'd3;
  localparam logic [2:0] S_PRESS2 = 3'd4;

  localparam logic [1:0] EV_SHORT  = 2'd0;
  localparam logic [1:0] EV_LONG   = 2'd1;
  localparam logic [1:0] EV_DOUBLE = 2'd2;
  localparam logic [1:0] EV_REPEAT = 2'd3;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYCLES - 1);

  logic [3:0][2:0]       r_state;
  logic [3:0][CNT_W-1:0] r_cnt;
  logic [3:0]            r_slot_vld;
  logic [3:0][1:0]       r_slot_type;
  logic                  r_cmd_valid;
  logic [1:0]            r_cmd_key;
  logic [1:0]            r_cmd_type;
  logic                  r_ovf;

  logic [3:0][2:0]       w_state_d;
  logic [3:0][CNT_W-1:0] w_cnt_d;
  logic [3:0]            w_emit;
  logic [3:0][1:0]       w_emit_type;
  logic [3:0]            w_press;
  logic [3:0]            w_release;
  logic                  w_any;
  logic [1:0]            w_sel;
  logic                  w_load;
  logic [3:0]            w_drain;
  logic                  w_ovf;

  assign w_press   = key_flag & ~key_value;
  assign w_release = key_flag & key_value;

  // Release beats LONG/REPEAT and press beats the DOUBLE-window timeout.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_state_d[k]   = r_state[k];
      w_cnt_d[k]     = r_cnt[k];
      w_emit[k]      = 1'b0;
      w_emit_type[k] = EV_SHORT;
      case (r_state[k])
        S_IDLE: begin
          if (w_press[k]) begin
            w_state_d[k] = S_PRESS;
            w_cnt_d[k]   = '0;
          end
        end
        S_PRESS: begin
          if (w_release[k]) begin
            w_state_d[k] = S_WAIT2;
            w_cnt_d[k]   = '0;
          end else if (r_cnt[k] == LONG_LAST) begin
            w_emit[k]      = 1'b1;
            w_emit_type[k] = EV_LONG;
            w_state_d[k]   = S_HOLD;
            w_cnt_d[k]     = '0;
          end else begin
            w_cnt_d[k] = r_cnt[k] + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (w_release[k]) begin
            w_state_d[k] = S_IDLE;
            w_cnt_d[k]   = '0;
          end else if (r_cnt[k] == REP_LAST) begin
            w_emit[k]      = 1'b1;
            w_emit_type[k] = EV_REPEAT;
            w_cnt_d[k]     = '0;
          end else begin
            w_cnt_d[k] = r_cnt[k] + CNT_W'(1);
          end
        end
        S_WAIT2: begin
          if (w_press[k]) begin
            w_emit[k]      = 1'b1;
            w_emit_type[k] = EV_DOUBLE;
            w_state_d[k]   = S_PRESS2;
            w_cnt_d[k]     = '0;
          end else if (r_cnt[k] == DBL_LAST) begin
            w_emit[k]      = 1'b1;
            w_emit_type[k] = EV_SHORT;
            w_state_d[k]   = S_IDLE;
            w_cnt_d[k]     = '0;
          end else begin
            w_cnt_d[k] = r_cnt[k] + CNT_W'(1);
          end
        end
        S_PRESS2: begin
          if (w_release[k]) begin
            w_state_d[k] = S_IDLE;
          end
        end
        default: begin
          w_state_d[k] = S_IDLE;
          w_cnt_d[k]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Lowest-index full slot is drained whenever the output register can take a command.
  always_comb begin
    w_any = |r_slot_vld;
    w_sel = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_slot_vld[k]) w_sel = 2'(k);
    end
    w_load = ~r_cmd_valid | cmd_ready;
    for (int k = 0; k < 4; k++) begin
      w_drain[k] = w_load & w_any & (w_sel == 2'(k));
    end
    w_ovf = |(w_emit & r_slot_vld & ~w_drain);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_slot_vld  <= '0;
      r_slot_type <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_emit[k]) begin
          r_slot_vld[k]  <= 1'b1;
          r_slot_type[k] <= w_emit_type[k];
        end else if (w_drain[k]) begin
          r_slot_vld[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_key   <= 2'd0;
      r_cmd_type  <= 2'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_load) begin
        r_cmd_valid <= w_any;
        if (w_any) begin
          r_cmd_key  <= w_sel;
          r_cmd_type <= r_slot_type[w_sel];
        end
      end
    end
  end

  assign cmd_valid    = r_cmd_valid;
  assign cmd_key      = r_cmd_key;
  assign cmd_type     = r_cmd_type;
  assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios against fixed expectations plus a
// randomized run checked cycle by cycle against a timestamp-based reference model.
module tb_key_event_decoder;

  localparam int LONG = 100;
  localparam int REP  = 20;
  localparam int DBL  = 40;

  localparam int PH_IDLE  = 0;
  localparam int PH_DOWN  = 1;
  localparam int PH_HELD  = 2;
  localparam int PH_WAITR = 3;
  localparam int PH_DOWN2 = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] key_flag;
  logic [3:0] key_value;
  logic       cmd_valid;
  logic [1:0] cmd_key;
  logic [1:0] cmd_type;
  logic       cmd_ready;
  logic       evt_overflow;

  key_event_decoder #(
    .CNT_W        (32),
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .DBL_CYCLES   (DBL)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .cmd_valid   (cmd_valid),
    .cmd_key     (cmd_key),
    .cmd_type    (cmd_type),
    .cmd_ready   (cmd_ready),
    .evt_overflow(evt_overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [1:0] obs_key[$];
  logic [1:0] obs_type[$];
  int         obs_t[$];
  int         ovf_t[$];

  // Reference model: per-key phase plus the edge timestamps of the last press/release/LONG.
  int         m_ph[4];
  int         m_tp[4];
  int         m_tr[4];
  int         m_th[4];
  bit         m_pend[4];
  logic [1:0] m_ptype[4];
  bit         m_valid;
  logic [1:0] m_key;
  logic [1:0] m_type;
  bit         m_ovf;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_ph[k] = PH_IDLE; m_tp[k] = 0; m_tr[k] = 0; m_th[k] = 0;
      m_pend[k] = 1'b0; m_ptype[k] = 2'd0;
    end
    m_valid = 1'b0; m_key = 2'd0; m_type = 2'd0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int  e;
    int  sel;
    int  ev[4];
    bit  found;
    bit  ovf;
    bit  pr;
    bit  rl;
    e = cyc + 1;
    if (sys_rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      ev[k] = -1;
      pr = key_flag[k] && !key_value[k];
      rl = key_flag[k] && key_value[k];
      case (m_ph[k])
        PH_IDLE:  if (pr) begin m_ph[k] = PH_DOWN; m_tp[k] = e; end
        PH_DOWN: begin
          if (rl) begin m_ph[k] = PH_WAITR; m_tr[k] = e; end
          else if (e - m_tp[k] == LONG) begin ev[k] = 1; m_ph[k] = PH_HELD; m_th[k] = e; end
        end
        PH_HELD: begin
          if (rl) m_ph[k] = PH_IDLE;
          else if ((e - m_th[k]) % REP == 0) ev[k] = 3;
        end
        PH_WAITR: begin
          if (pr) begin ev[k] = 2; m_ph[k] = PH_DOWN2; end
          else if (e - m_tr[k] == DBL) begin ev[k] = 0; m_ph[k] = PH_IDLE; end
        end
        default:  if (rl) m_ph[k] = PH_IDLE;
      endcase
    end
    found = 1'b0;
    sel   = 0;
    if (!m_valid || cmd_ready) begin
      for (int k = 3; k >= 0; k--) if (m_pend[k]) begin found = 1'b1; sel = k; end
      m_valid = found;
      if (found) begin
        m_key = 2'(sel);
        m_type = m_ptype[sel];
        m_pend[sel] = 1'b0;
      end
    end
    ovf = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ev[k] >= 0) begin
        if (m_pend[k]) ovf = 1'b1;
        m_pend[k]  = 1'b1;
        m_ptype[k] = 2'(ev[k]);
      end
    end
    m_ovf = ovf;
  endtask

  // Advance one clock: update model with the inputs present at the edge and log handshakes.
  task automatic tick();
    model_step();
    if (cmd_valid && cmd_ready) begin
      obs_key.push_back(cmd_key);
      obs_type.push_back(cmd_type);
      obs_t.push_back(cyc);
    end
    if (evt_overflow) ovf_t.push_back(cyc);
    @(posedge sys_clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [3:0] f, input logic [3:0] v);
    key_flag  = f;
    key_value = v;
    tick();
    key_flag  = 4'b0000;
  endtask

  task automatic clear_obs();
    obs_key.delete(); obs_type.delete(); obs_t.delete(); ovf_t.delete();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; cmd_ready = 1'b0; key_flag = 4'b0000; key_value = 4'b1111;
    idle(3);
    n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
    n_vec++; if (cmd_key !== 2'd0) begin n_err++; $display("FAIL reset_key: got %0d want 0", cmd_key); end
    n_vec++; if (cmd_type !== 2'd0) begin n_err++; $display("FAIL reset_type: got %0d want 0", cmd_type); end
    n_vec++; if (evt_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", evt_overflow); end
    sys_rst = 1'b0;
    idle(2);
  endtask

  task automatic test_short();
    int r;
    clear_obs(); cmd_ready = 1'b1;
    drive(4'b0001, 4'b0000);
    idle(29);
    drive(4'b0001, 4'b1111);
    r = cyc;
    idle(60);
    n_vec++; if (obs_key.size() != 1) begin n_err++; $display("FAIL short_count: got %0d want 1", obs_key.size()); end
    n_vec++; if (obs_key[0] !== 2'd0) begin n_err++; $display("FAIL short_key: got %0d want 0", obs_key[0]); end
    n_vec++; if (obs_type[0] !== 2'd0) begin n_err++; $display("FAIL short_type: got %0d want 0", obs_type[0]); end
    n_vec++; if (obs_t[0] != r + DBL + 1) begin n_err++; $display("FAIL short_time: got %0d want %0d", obs_t[0], r + DBL + 1); end
  endtask

  task automatic test_long_repeat();
    int p;
    logic [1:0] exp_type[3];
    int exp_t[3];
    clear_obs(); cmd_ready = 1'b1;
    drive(4'b0100, 4'b0000);
    p = cyc;
    idle(149);
    drive(4'b0100, 4'b1111);
    idle(10);
    exp_type[0] = 2'd1; exp_type[1] = 2'd3; exp_type[2] = 2'd3;
    exp_t[0] = p + LONG + 1; exp_t[1] = p + LONG + REP + 1; exp_t[2] = p + LONG + 2 * REP + 1;
    n_vec++; if (obs_key.size() != 3) begin n_err++; $display("FAIL long_count: got %0d want 3", obs_key.size()); end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (obs_key[i] !== 2'd2 || obs_type[i] !== exp_type[i] || obs_t[i] != exp_t[i]) begin
        n_err++;
        $display("FAIL long_cmd%0d: got key %0d type %0d t %0d want key 2 type %0d t %0d",
                 i, obs_key[i], obs_type[i], obs_t[i], exp_type[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_double();
    int p2;
    clear_obs(); cmd_ready = 1'b1;
    drive(4'b0010, 4'b0000);
    idle(9);
    drive(4'b0010, 4'b1111);
    idle(14);
    drive(4'b0010, 4'b0000);
    p2 = cyc;
    idle(4);
    drive(4'b0010, 4'b1111);
    idle(60);
    n_vec++; if (obs_key.size() != 1) begin n_err++; $display("FAIL dbl_count: got %0d want 1", obs_key.size()); end
    n_vec++;
    if (obs_key[0] !== 2'd1 || obs_type[0] !== 2'd2 || obs_t[0] != p2 + 1) begin
      n_err++;
      $display("FAIL dbl_cmd: got key %0d type %0d t %0d want key 1 type 2 t %0d",
               obs_key[0], obs_type[0], obs_t[0], p2 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int r;
    clear_obs(); cmd_ready = 1'b1;
    drive(4'b1001, 4'b0000);
    idle(19);
    drive(4'b1001, 4'b1111);
    r = cyc;
    idle(60);
    n_vec++; if (obs_key.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", obs_key.size()); end
    n_vec++;
    if (obs_key[0] !== 2'd0 || obs_type[0] !== 2'd0 || obs_t[0] != r + DBL + 1) begin
      n_err++;
      $display("FAIL b2b_first: got key %0d type %0d t %0d want key 0 type 0 t %0d",
               obs_key[0], obs_type[0], obs_t[0], r + DBL + 1);
    end
    n_vec++;
    if (obs_key[1] !== 2'd3 || obs_type[1] !== 2'd0 || obs_t[1] != r + DBL + 2) begin
      n_err++;
      $display("FAIL b2b_second: got key %0d type %0d t %0d want key 3 type 0 t %0d",
               obs_key[1], obs_type[1], obs_t[1], r + DBL + 2);
    end
    n_vec++; if (ovf_t.size() != 0) begin n_err++; $display("FAIL b2b_ovf: got %0d pulses want 0", ovf_t.size()); end
  endtask

  task automatic test_backpressure();
    int p;
    clear_obs(); cmd_ready = 1'b0;
    drive(4'b0010, 4'b0000);
    p = cyc;
    idle(110);
    n_vec++;
    if (cmd_valid !== 1'b1 || cmd_key !== 2'd1 || cmd_type !== 2'd1) begin
      n_err++;
      $display("FAIL bp_hold_early: got v %b key %0d type %0d want v 1 key 1 type 1", cmd_valid, cmd_key, cmd_type);
    end
    idle(34);
    drive(4'b0010, 4'b1111);
    n_vec++;
    if (cmd_valid !== 1'b1 || cmd_key !== 2'd1 || cmd_type !== 2'd1) begin
      n_err++;
      $display("FAIL bp_hold_late: got v %b key %0d type %0d want v 1 key 1 type 1", cmd_valid, cmd_key, cmd_type);
    end
    cmd_ready = 1'b1;
    idle(5);
    n_vec++;
    if (ovf_t.size() != 1 || ovf_t[0] != p + LONG + 2 * REP) begin
      n_err++;
      $display("FAIL bp_ovf: got %0d pulses first t %0d want 1 at %0d", ovf_t.size(), ovf_t[0], p + LONG + 2 * REP);
    end
    n_vec++; if (obs_key.size() != 2) begin n_err++; $display("FAIL bp_count: got %0d want 2", obs_key.size()); end
    n_vec++;
    if (obs_key[0] !== 2'd1 || obs_type[0] !== 2'd1 || obs_key[1] !== 2'd1 || obs_type[1] !== 2'd3) begin
      n_err++;
      $display("FAIL bp_order: got (%0d,%0d) (%0d,%0d) want (1,1) (1,3)",
               obs_key[0], obs_type[0], obs_key[1], obs_type[1]);
    end
  endtask

  task automatic test_reset_mid_hold();
    int r;
    clear_obs(); cmd_ready = 1'b0;
    drive(4'b0100, 4'b0000);
    idle(110);
    n_vec++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %b want 1", cmd_valid); end
    #2 sys_rst = 1'b1;
    #1;
    n_vec++;
    if (cmd_valid !== 1'b0 || cmd_key !== 2'd0 || cmd_type !== 2'd0 || evt_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got v %b key %0d type %0d ovf %b want all 0", cmd_valid, cmd_key, cmd_type, evt_overflow);
    end
    model_reset();
    tick();
    sys_rst = 1'b0;
    cmd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_vec++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_%0d: got v %b want 0", i, cmd_valid); end
    end
    drive(4'b0100, 4'b1111);
    idle(5);
    n_vec++; if (obs_key.size() != 0) begin n_err++; $display("FAIL rst_no_cmd: got %0d want 0", obs_key.size()); end
    drive(4'b0100, 4'b0000);
    idle(5);
    drive(4'b0100, 4'b1111);
    r = cyc;
    idle(45);
    n_vec++;
    if (obs_key.size() != 1 || obs_key[0] !== 2'd2 || obs_type[0] !== 2'd0 || obs_t[0] != r + DBL + 1) begin
      n_err++;
      $display("FAIL rst_new_short: got n %0d key %0d type %0d t %0d want n 1 key 2 type 0 t %0d",
               obs_key.size(), obs_key[0], obs_type[0], obs_t[0], r + DBL + 1);
    end
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    int         r;
    lvl = 4'b1111;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 4; k++) begin
        r = int'($urandom_range(0, 99));
        key_flag[k] = 1'b0;
        key_value[k] = 1'($urandom_range(0, 1));
        if (r < 2) begin
          lvl[k] = ~lvl[k];
          key_flag[k] = 1'b1;
          key_value[k] = lvl[k];
        end else if (r < 4) begin
          key_flag[k] = 1'b1;
          key_value[k] = lvl[k];
        end
      end
      cmd_ready = ($urandom_range(0, 3) != 0);
      tick();
      n_vec++; if (cmd_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, cmd_valid, m_valid); end
      if (m_valid) begin
        n_vec++;
        if (cmd_key !== m_key || cmd_type !== m_type) begin
          n_err++;
          $display("FAIL rnd_cmd@%0d: got key %0d type %0d want key %0d type %0d", cyc, cmd_key, cmd_type, m_key, m_type);
        end
      end
      n_vec++; if (evt_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", cyc, evt_overflow, m_ovf); end
    end
    key_flag = 4'b0000;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short();
    test_long_repeat();
    test_double();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
Consumes the per-key debounced outputs (one-cycle valid flag plus stable level, 0 = pressed) for the four car-control keys. Classifies each key's activity into SHORT, LONG, DOUBLE and REPEAT events. Queues one pending event per key and presents the events through a single valid/ready command port to the mode/motion controller.

Parameters:
CNT_W, 32, width of per-key duration counters
LONG_CYCLES, 100, held cycles after press that produce LONG
REPEAT_CYCLES, 20, cycles between REPEAT events while held after LONG
DBL_CYCLES, 40, window after a short release in which a second press makes DOUBLE

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  reset, asynchronous, active-high
key_flag  in  4  bit k: one-cycle "debounced level valid" pulse for key k
key_value  in  4  bit k: debounced level of key k (0 = pressed, 1 = released), sampled only when key_flag[k]=1
cmd_valid  out  1  command available
cmd_key  out  2  key index of the command
cmd_type  out  2  0=SHORT, 1=LONG, 2=DOUBLE, 3=REPEAT
cmd_ready  in  1  consumer accepts the command
evt_overflow  out  1  one-cycle pulse: a pending event was overwritten before it was drained

Behaviour:
- Reset (async assert, sync release): all key FSMs go to IDLE with counters 0, pending slots empty, cmd_valid=0, cmd_key=0, cmd_type=0, evt_overflow=0. Reset mid-press discards all in-flight state and events.
- press(k) = key_flag[k] & ~key_value[k]; release(k) = key_flag[k] & key_value[k]. A flag that does not change the state's level expectation is ignored (e.g. release in IDLE).
- Per-key FSM, four independent copies, per-key counter cnt:
  - IDLE: press -> PRESS, cnt=0.
  - PRESS: cnt increments each cycle. If release occurs while cnt < LONG_CYCLES-1 -> WAIT2, cnt=0. If cnt == LONG_CYCLES-1 and no release in that cycle -> emit LONG, go to HOLD, cnt=0. If release and cnt == LONG_CYCLES-1 occur in the same cycle, the release wins (-> WAIT2).
  - HOLD: cnt increments. At cnt == REPEAT_CYCLES-1, emit REPEAT and set cnt=0. Release -> IDLE with no event; release beats REPEAT in the same cycle.
  - WAIT2: cnt increments. Press -> emit DOUBLE, go to PRESS2. At cnt == DBL_CYCLES-1 with no press -> emit SHORT, go to IDLE. Press beats timeout in the same cycle.
  - PRESS2: release -> IDLE, no event. No long detection in this state.
- Counters never wrap: the compare-and-clear rules bound them below every *_CYCLES value.
- Pending slot per key (valid bit + 2-bit type):
  - An event emitted in cycle N is visible in the slot after edge N.
  - If the slot is full and is not being drained that cycle, the new event overwrites it and evt_overflow pulses high for one cycle.
  - If the slot is drained in the same cycle, the new event fills the slot with no overflow.
- Output register:
  - When cmd_valid=0, or when cmd_valid & cmd_ready, the register loads the lowest-index full slot at the next edge and clears that slot. cmd_valid then equals "any slot was full".
  - While cmd_valid & ~cmd_ready, cmd_valid, cmd_key and cmd_type hold stable, even if a lower-index slot fills.
  - Latency from event emission to cmd_valid is 2 edges when the output register is empty.
  - Back-to-back acceptance allows 1 command per cycle.
- All outputs are registered. Keys operate fully concurrently.

Test Plan:
- Key0 press, release after 30 cycles, idle 60 -> one command: cmd_key=0, cmd_type=0 (SHORT), DBL_CYCLES after release; no other commands.
- Key2 press held 150 cycles -> LONG at press+100, REPEAT at +120 and +140. Release produces nothing. Commands arrive in order 1, 3, 3 with cmd_key=2.
- Key1 press 10, release, press again 15 cycles later, release -> single DOUBLE (type 2, key 1); no SHORT emitted.
- Key3 and key0 both emit SHORT in the same cycle, cmd_ready=1 -> key0 command then key3 on consecutive cycles; no overflow.
- Hold cmd_ready=0 while key1 produces LONG then REPEAT -> first command stays stable. The pending REPEAT overwrites LONG? No: LONG is already in the output register, so REPEAT sits pending. A second REPEAT overwrites it with an evt_overflow pulse. Releasing ready yields LONG then REPEAT.
- Assert sys_rst during key2 HOLD with cmd_valid=1 -> all outputs 0 immediately. After release, no stale REPEAT and no cmd_valid until a new press sequence.
